fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  LEGv8 instruction-fetch stage: owns the PC, drives the word address into the
//  combinational instruction ROM (imem) and registers the returned word into the
//  IF/ID pipeline register. It handles stall, branch redirect, flush and halt.
//  Downstream is decode, which consumes instr_o/pc_o/valid_o.
// PARAMETERS
//  N         64     PC / datapath width
//  IMEM_AW   8      imem word-address width (256 words)
//  RESET_PC  '0     PC value loaded on reset
// PORTS
//  clk            in   1        clock, rising edge
//  reset          in   1        asynchronous, active-low reset (0 = in reset)
//  stall_i        in   1        hazard unit: hold PC and IF/ID
//  flush_i        in   1        squash the instruction entering IF/ID
//  pcsrc_i        in   1        branch taken, redirect PC
//  branch_tgt_i   in   N        redirect target (byte address)
//  imem_addr_o    out  IMEM_AW  = pc_q[IMEM_AW+1:2], combinational from pc_q
//  imem_q_i       in   32       instruction word from imem (combinational)
//  pc_o           out  N        IF/ID: PC of instr_o
//  instr_o        out  32       IF/ID: instruction word
//  valid_o        out  1        IF/ID: instr_o is real (not a bubble)
//  halted_o       out  1        fetch is parked on the halt instruction
//  fetch_cnt_o    out  32       count of valid instructions written to IF/ID
// BEHAVIOUR
//  - Reset (async, reset==0): pc_q=RESET_PC, instr_o=NOP_INSN (32'h8b1f03ff),
//    pc_o=0, valid_o=0, halted_o=0, fetch_cnt_o=0, state=BOOT.
//  - Latency: the word at pc_q appears on instr_o one cycle later (imem has no
//    latency). PC increment is +4 modulo 2^N. The address wraps modulo 256 words.
//    PC[1:0] is ignored.
//  - FSM fetch_state_t {BOOT, RUN, HALT}:
//    BOOT: this is one bubble cycle after reset release. IF/ID loads NOP with
//          valid=0, PC holds. The next state is RUN.
//    RUN:  this is normal fetch. IF/ID captures {pc_q, imem_q_i, 1}. If the captured
//          word == HALT_INSN (32'hb400001f) and there is no redirect or flush that
//          cycle, go to HALT with pc_q held at the halt address.
//    HALT: pc_q is frozen, IF/ID loads NOP with valid=0, and halted_o=1.
//          pcsrc_i=1 loads branch_tgt_i and returns to RUN (this case is an older
//          branch resolving). stall_i and flush_i have no effect here.
//  - Per-cycle priority (RUN): pcsrc_i > stall_i > normal.
//    pcsrc_i=1: pc_q<=branch_tgt_i, and IF/ID loads a bubble, even if stall_i=1.
//    stall_i=1 (no redirect): pc_q and all IF/ID outputs hold their value, and
//      fetch_cnt_o holds.
//    flush_i=1 (no stall): IF/ID loads a bubble and PC advances by +4.
//    flush_i=1 with stall_i=1: IF/ID loads a bubble and PC holds.
//  - A bubble is instr_o=NOP_INSN, valid_o=0, and pc_o keeps its previous value.
//  - fetch_cnt_o increments only when IF/ID captures with valid=1. It wraps at 2^32.
//  - When reset asserts mid-operation, all state clears immediately. No partial
//    IF/ID contents survive.
// STRUCTURE
//  - legv8_pkg contains NOP_INSN, HALT_INSN, fetch_state_t and an IF/ID packed
//    struct type if_id_t {pc, instr, valid}.
//  - There is one sub-module, if_id_reg: an async-active-low-reset register of
//    if_id_t with load/bubble/hold controls. The FSM and PC logic stay in fetch_stage.
//  - The bench instantiates imem alongside fetch_stage. imem_addr_o connects to
//    imem.addr and imem.q connects to imem_q_i.
// TESTING
//  1 Reset, then release: cycle 1 valid_o=0 (BOOT). Then instr_o=rom[0], pc_o=0,
//    and next cycle pc_o=4 with instr_o=rom[1].
//  2 stall_i=1 for 3 cycles at pc_q=8: imem_addr_o=2 is steady. IF/ID and
//    fetch_cnt_o are unchanged. Release gives pc_o=8, then 12.
//  3 pcsrc_i=1 with branch_tgt_i=0x40 while stall_i=1: next cycle valid_o=0 and
//    imem_addr_o=16. The cycle after gives instr_o=rom[16] and pc_o=0x40.
//  4 flush_i=1 at pc_q=0x10: IF/ID bubble (instr_o=32'h8b1f03ff, valid_o=0).
//    The next capture is pc_o=0x14.
//  5 Run into rom[20]=32'hb400001f: halted_o=1 one cycle after it is captured.
//    PC is frozen at 0x50 and fetch_cnt_o is frozen. Then pcsrc_i=1 with
//    branch_tgt_i=0 gives RUN and a refetch of rom[0].
//  6 Assert reset mid-stream (asynchronously, between edges): all outputs go to
//    their reset values immediately. branch_tgt_i=0xFFFF_FFFF_FFFF_FFFC followed
//    by +4 gives pc_q=0, which is the wrap check.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 fetch definitions: fixed instruction encodings, fetch FSM states,
// and the IF/ID pipeline register layout.
package legv8_pkg;

  localparam int XLEN = 64;

  localparam logic [31:0] NOP_INSN  = 32'h8b1f03ff;
  localparam logic [31:0] HALT_INSN = 32'hb400001f;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            valid;
  } if_id_t;

  function automatic logic is_halt(input logic [31:0] word);
    return word == HALT_INSN;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. A bubble overrides load and keeps the previous pc
// so decode still sees where the squashed slot came from.
module if_id_reg
  import legv8_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   bubble,
  input  if_id_t d,
  output if_id_t q
);

  // IF/ID storage: reset, bubble, load or hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= {{XLEN{1'b0}}, NOP_INSN, 1'b0};
    end else if (bubble) begin
      q.instr <= NOP_INSN;
      q.valid <= 1'b0;
    end else if (load) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/imem.sv
// Combinational-read instruction ROM with a clocked preload port.
module imem #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] addr,
  output logic [31:0]   q
);

  logic [31:0] mem_r [2**AW];

  // Preload write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end else begin
      mem_r[waddr] <= mem_r[waddr];
    end
  end

  assign q = mem_r[addr];

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 instruction fetch: PC ownership, imem addressing, IF/ID capture,
// redirect/stall/flush handling and halt parking.
module fetch_stage
  import legv8_pkg::*;
#(
  parameter int            N        = 64,
  parameter int            IMEM_AW  = 8,
  parameter logic [N-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               pcsrc_i,
  input  logic [N-1:0]       branch_tgt_i,
  output logic [IMEM_AW-1:0] imem_addr_o,
  input  logic [31:0]        imem_q_i,
  output logic [N-1:0]       pc_o,
  output logic [31:0]        instr_o,
  output logic               valid_o,
  output logic               halted_o,
  output logic [31:0]        fetch_cnt_o
);

  fetch_state_t state_r, state_s;
  logic [N-1:0] pc_r, pc_s, pc_inc_s;
  logic         load_s, bubble_s, halted_s;
  logic [31:0]  cnt_r;
  if_id_t       if_id_d_s, if_id_q_s;

  assign pc_inc_s    = pc_r + N'(3'd4);
  assign imem_addr_o = pc_r[IMEM_AW+1:2];

  // Next-state, next-PC and IF/ID control; redirect beats stall beats normal fetch
  always_comb begin
    state_s  = state_r;
    pc_s     = pc_r;
    load_s   = 1'b0;
    bubble_s = 1'b0;
    case (state_r)
      BOOT: begin
        bubble_s = 1'b1;
        state_s  = RUN;
      end
      RUN: begin
        if (pcsrc_i) begin
          pc_s     = branch_tgt_i;
          bubble_s = 1'b1;
        end else if (stall_i) begin
          bubble_s = flush_i;
        end else if (flush_i) begin
          pc_s     = pc_inc_s;
          bubble_s = 1'b1;
        end else begin
          load_s = 1'b1;
          if (is_halt(imem_q_i)) begin
            state_s = HALT;
          end else begin
            pc_s = pc_inc_s;
          end
        end
      end
      HALT: begin
        bubble_s = 1'b1;
        if (pcsrc_i) begin
          pc_s    = branch_tgt_i;
          state_s = RUN;
        end else begin
          state_s = HALT;
        end
      end
      default: begin
        bubble_s = 1'b1;
        state_s  = BOOT;
      end
    endcase
    halted_s = (state_s == HALT);
  end

  assign if_id_d_s = {XLEN'(pc_r), imem_q_i, 1'b1};

  // Fetch FSM, PC, halt flag and valid-capture counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= BOOT;
      pc_r     <= RESET_PC;
      halted_o <= 1'b0;
      cnt_r    <= 32'd0;
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      halted_o <= halted_s;
      if (load_s) begin
        cnt_r <= cnt_r + 32'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  if_id_reg u_if_id (
    .clk    (clk),
    .rst_n  (reset),
    .load   (load_s),
    .bubble (bubble_s),
    .d      (if_id_d_s),
    .q      (if_id_q_s)
  );

  assign pc_o        = N'(if_id_q_s.pc);
  assign instr_o     = if_id_q_s.instr;
  assign valid_o     = if_id_q_s.valid;
  assign fetch_cnt_o = cnt_r;

endmodule
